// File: rtl/systolic_result_drain.sv
// Captures the systolic array's flat accumulator vector on start and streams it
// out row-major, one saturated element per valid/ready beat.
module systolic_result_drain #(
  parameter int WIDTH      = 8,
  parameter int ARRAY_SIZE = 4,
  parameter int OUT_WIDTH  = 16,
  localparam int RES_W     = 2*WIDTH + $clog2(ARRAY_SIZE),
  localparam int N         = ARRAY_SIZE*ARRAY_SIZE,
  localparam int RC_W      = $clog2(ARRAY_SIZE),
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [RES_W*N-1:0]   result_in,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [OUT_WIDTH-1:0] m_data,
  output logic [RC_W-1:0]      m_row,
  output logic [RC_W-1:0]      m_col,
  output logic                 m_sat,
  output logic                 m_last,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);

  state_t                  state_reg, state_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    overrun_reg, overrun_next;
  logic                    capture;
  logic                    drop;
  logic                    handshake;
  logic signed [RES_W-1:0] elems [N];
  logic signed [RES_W-1:0] elem_sel;

  // Capture buffer: one register per element, loaded only on capture.
  for (genvar gi = 0; gi < N; gi++) begin : g_elem
    logic signed [RES_W-1:0] elem_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        elem_reg <= '0;
      end else if (capture) begin
        elem_reg <= result_in[RES_W*(gi+1)-1 -: RES_W];
      end
    end

    assign elems[gi] = elem_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      overrun_reg <= overrun_next;
    end
  end

  assign handshake = (state_reg == STREAM) && m_ready;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    capture    = 1'b0;
    drop       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (handshake) begin
          if (idx_reg == LAST_IDX) begin
            idx_next = '0;
            // A start on the final handshake refills the buffer with no bubble.
            if (start) begin
              capture = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            idx_next = idx_reg + IDX_W'(1);
          end
        end
        if (start && !(handshake && (idx_reg == LAST_IDX))) begin
          drop = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase
  end

  // A dropping start outranks a simultaneous clear.
  always_comb begin
    overrun_next = overrun_reg;
    if (drop) begin
      overrun_next = 1'b1;
    end else if (clr_overrun) begin
      overrun_next = 1'b0;
    end
  end

  assign elem_sel = elems[idx_reg];
  assign busy     = (state_reg == STREAM);
  assign m_valid  = busy;
  assign overrun  = overrun_reg;
  assign m_row    = RC_W'(idx_reg / IDX_W'(ARRAY_SIZE));
  assign m_col    = RC_W'(idx_reg % IDX_W'(ARRAY_SIZE));
  assign m_last   = (idx_reg == LAST_IDX) && busy;

  if (OUT_WIDTH >= RES_W) begin : g_ext
    assign m_data = OUT_WIDTH'(elem_sel);
    assign m_sat  = 1'b0;
  end else begin : g_sat
    localparam logic signed [RES_W-1:0] SAT_MAX =
      {{(RES_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RES_W-1:0] SAT_MIN =
      {{(RES_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    always_comb begin
      m_data = elem_sel[OUT_WIDTH-1:0];
      m_sat  = 1'b0;
      if (elem_sel > SAT_MAX) begin
        m_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        m_sat  = 1'b1;
      end else if (elem_sel < SAT_MIN) begin
        m_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        m_sat  = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: scoreboard queue filled on capture,
// drained and compared on each valid beat; a second 20-bit-output instance checks extension.
module tb_systolic_result_drain;

  localparam int WIDTH = 8;
  localparam int AS    = 4;
  localparam int OW    = 16;
  localparam int OWW   = 20;
  localparam int RES_W = 18;
  localparam int N     = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, m_ready, clr_overrun;
  logic [RES_W*N-1:0] result_in;
  logic             m_valid, m_sat, m_last, busy, overrun;
  logic [OW-1:0]    m_data;
  logic [1:0]       m_row, m_col;

  logic             start_w, m_ready_w, clr_w;
  logic [RES_W*N-1:0] result_w;
  logic             m_valid_w, m_sat_w, m_last_w, busy_w, overrun_w;
  logic [OWW-1:0]   m_data_w;
  logic [1:0]       m_row_w, m_col_w;

  systolic_result_drain #(.WIDTH(WIDTH), .ARRAY_SIZE(AS), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .start(start), .result_in(result_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_row(m_row),
    .m_col(m_col), .m_sat(m_sat), .m_last(m_last), .busy(busy),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  systolic_result_drain #(.WIDTH(WIDTH), .ARRAY_SIZE(AS), .OUT_WIDTH(OWW)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .result_in(result_w),
    .m_valid(m_valid_w), .m_ready(m_ready_w), .m_data(m_data_w), .m_row(m_row_w),
    .m_col(m_col_w), .m_sat(m_sat_w), .m_last(m_last_w), .busy(busy_w),
    .overrun(overrun_w), .clr_overrun(clr_w)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic [1:0]    row;
    logic [1:0]    col;
    logic          sat;
    logic          last;
  } exp_t;

  exp_t q[$];
  logic exp_ovr;
  int   vectors = 0;
  int   miscompares = 0;

  logic [RES_W*N-1:0] data_a, data_b, data_s, data_wv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_all(input logic [RES_W*N-1:0] d);
    logic signed [RES_W-1:0] e;
    int   v;
    exp_t x;
    for (int i = 0; i < N; i++) begin
      e = d[RES_W*i +: RES_W];
      v = int'(e);
      x.row  = 2'(i / AS);
      x.col  = 2'(i % AS);
      x.last = (i == N-1);
      if (v > 32767) begin
        x.data = 16'h7fff;
        x.sat  = 1'b1;
      end else if (v < -32768) begin
        x.data = 16'h8000;
        x.sat  = 1'b1;
      end else begin
        x.data = 16'(v);
        x.sat  = 1'b0;
      end
      q.push_back(x);
    end
  endtask

  // One clock step: drive at negedge, check against the model, advance the model.
  task automatic tick(input logic s, input logic [RES_W*N-1:0] d, input logic r,
                      input logic c, input logic rs);
    exp_t e;
    logic hs, hs_last, cap, drp;
    start = s; result_in = d; m_ready = r; clr_overrun = c; rst = rs;
    #1;
    chk("m_valid", m_valid, q.size() > 0);
    chk("busy", busy, q.size() > 0);
    chk("overrun", overrun, exp_ovr);
    if (q.size() > 0) begin
      e = q[0];
      chk("m_data", m_data, e.data);
      chk("m_row", m_row, e.row);
      chk("m_col", m_col, e.col);
      chk("m_sat", m_sat, e.sat);
      chk("m_last", m_last, e.last);
    end
    hs      = (q.size() > 0) && r;
    hs_last = hs && (q.size() == 1);
    cap     = s && ((q.size() == 0) || hs_last);
    drp     = s && !cap;
    if (rs) begin
      q.delete();
      exp_ovr = 1'b0;
    end else begin
      if (hs) void'(q.pop_front());
      if (cap) push_all(d);
      if (drp) exp_ovr = 1'b1;
      else if (c) exp_ovr = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input logic [RES_W*N-1:0] junk);
    int guard = 0;
    while (q.size() > 0 && guard < 200) begin
      tick(1'b0, junk, 1'b1, 1'b0, 1'b0);
      guard++;
    end
    chk("drain_done", q.size(), 0);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_row"}, m_row, 0);
    chk({tag, "_col"}, m_col, 0);
    chk({tag, "_sat"}, m_sat, 0);
    chk({tag, "_last"}, m_last, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      data_a[RES_W*i +: RES_W] = RES_W'(i + 1);
      data_b[RES_W*i +: RES_W] = RES_W'(100*i - 700);
      data_s[RES_W*i +: RES_W] = RES_W'(i*5000 - 40000);
      data_wv[RES_W*i +: RES_W] = RES_W'(i);
    end
    data_s[RES_W*0 +: RES_W] = RES_W'(40000);
    data_s[RES_W*1 +: RES_W] = RES_W'(-40000);
    data_s[RES_W*2 +: RES_W] = RES_W'(32767);
    data_s[RES_W*3 +: RES_W] = RES_W'(-5);
    data_wv[RES_W*0 +: RES_W] = RES_W'(-131072);
    data_wv[RES_W*1 +: RES_W] = RES_W'(131071);

    exp_ovr = 1'b0;
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; clr_overrun = 1'b0; result_in = '0;
    start_w = 1'b0; m_ready_w = 1'b0; clr_w = 1'b0; result_w = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk_zero_outputs("rst");
    chk("rst_valid_w", m_valid_w, 0);

    // Basic order with m_ready held high.
    tick(1'b1, data_a, 1'b1, 1'b0, 1'b0);
    drain(data_b);
    tick(1'b0, data_b, 1'b1, 1'b0, 1'b0);

    // Backpressure: ready pattern 1,0,0,1 repeating; new data on the bus is ignored.
    tick(1'b1, data_a, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 200 && q.size() > 0; k++)
      tick(1'b0, data_b, (k % 4 == 0) || (k % 4 == 3), 1'b0, 1'b0);
    chk("bp_done", q.size(), 0);

    // Saturation.
    tick(1'b1, data_s, 1'b1, 1'b0, 1'b0);
    drain(data_a);

    // Overrun during beat 5, then back-to-back recapture on the final beat.
    tick(1'b1, data_a, 1'b1, 1'b0, 1'b0);
    repeat (4) tick(1'b0, data_b, 1'b1, 1'b0, 1'b0);
    tick(1'b1, data_b, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 50 && q.size() > 1; k++)
      tick(1'b0, data_b, 1'b1, 1'b0, 1'b0);
    tick(1'b1, data_b, 1'b1, 1'b0, 1'b0);
    tick(1'b0, data_a, 1'b1, 1'b0, 1'b0);
    tick(1'b1, data_a, 1'b1, 1'b1, 1'b0);
    tick(1'b0, data_a, 1'b1, 1'b0, 1'b0);
    tick(1'b0, data_a, 1'b0, 1'b1, 1'b0);
    drain(data_a);

    // Reset at beat 7 with overrun set beforehand.
    tick(1'b1, data_a, 1'b1, 1'b0, 1'b0);
    repeat (2) tick(1'b0, data_a, 1'b1, 1'b0, 1'b0);
    tick(1'b1, data_b, 1'b0, 1'b0, 1'b0);
    repeat (4) tick(1'b0, data_a, 1'b1, 1'b0, 1'b0);
    tick(1'b0, data_a, 1'b1, 1'b0, 1'b1);
    tick(1'b0, data_a, 1'b1, 1'b0, 1'b0);
    chk_zero_outputs("post_rst");
    tick(1'b1, data_a, 1'b1, 1'b0, 1'b0);
    drain(data_b);

    // Wide output instance: sign extension, never saturates.
    start_w = 1'b1; result_w = data_wv;
    tick(1'b0, data_a, 1'b0, 1'b0, 1'b0);
    start_w = 1'b0; result_w = '0;
    chk("wide_valid", m_valid_w, 1);
    chk("wide_data0", m_data_w, 20'hE0000);
    chk("wide_sat0", m_sat_w, 0);
    m_ready_w = 1'b1;
    tick(1'b0, data_a, 1'b0, 1'b0, 1'b0);
    chk("wide_data1", m_data_w, 20'h1FFFF);
    chk("wide_sat1", m_sat_w, 0);
    chk("wide_col1", m_col_w, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Sits on the output side of the systolic matrix-multiply array.
- On a start pulse it captures the array's flat result vector, which holds ARRAY_SIZE*ARRAY_SIZE signed accumulators.
- It then streams the elements out one per beat, row-major, over a valid/ready interface, saturating each element to OUT_WIDTH.
- It gives the downstream DMA/writeback logic a narrow, back-pressurable stream instead of a wide parallel bus.

Parameters:
- WIDTH, 8, operand width of the array (sets accumulator width)
- ARRAY_SIZE, 4, rows = cols of the array; N = ARRAY_SIZE*ARRAY_SIZE elements
- OUT_WIDTH, 16, width of each streamed element after signed saturation/extension

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  capture pulse; result_in is valid this cycle
- result_in  in  RES_W*N  flat result; RES_W = 2*WIDTH+$clog2(ARRAY_SIZE); element (k,l) occupies bits [RES_W*(ARRAY_SIZE*k+l+1)-1 -: RES_W], signed
- m_valid  out  1  output beat valid
- m_ready  in  1  downstream accept
- m_data  out  OUT_WIDTH  saturated element, signed
- m_row  out  $clog2(ARRAY_SIZE)  row index k of current beat
- m_col  out  $clog2(ARRAY_SIZE)  column index l of current beat
- m_sat  out  1  current element was clipped
- m_last  out  1  current beat is element N-1
- busy  out  1  high while in STREAM
- overrun  out  1  sticky: a start was dropped
- clr_overrun  in  1  clears overrun

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, and has priority over all else.
- Reset values:
  - state=IDLE; capture buffer all 0; idx=0.
  - m_valid=0, busy=0, overrun=0.
  - m_data/m_row/m_col/m_sat/m_last reflect idx=0 of a zero buffer, so all read 0.
- FSM states:
  - IDLE: start=1 → copy result_in into buffer, idx<=0, go to STREAM.
  - STREAM: m_valid=1. Handshake = m_valid&m_ready.
    - Handshake with idx<N-1 → idx<=idx+1.
    - Handshake with idx==N-1 and start=0 → IDLE, idx<=0.
    - Handshake with idx==N-1 and start=1 → recapture result_in, idx<=0, stay in STREAM (back-to-back, no bubble).
- Dropped starts:
  - start in STREAM other than on the final handshake: not captured, overrun<=1, streaming unaffected.
  - overrun stays 1 until clr_overrun or rst. If clr_overrun and a dropping start occur in the same cycle, set wins.
- Latency and throughput:
  - start at cycle t → m_valid=1 at t+1 with element (0,0).
  - With m_ready held high, N beats on consecutive cycles; busy falls at t+N+1.
- Output stability:
  - While m_valid=1 and m_ready=0, all m_* outputs hold stable.
  - All m_* outputs are derived from registered buffer/idx only; no combinational path from m_ready or start to m_data.
- Indexing: m_row=idx/ARRAY_SIZE, m_col=idx%ARRAY_SIZE; m_last=(idx==N-1)&&busy.
- Saturation, with e = buffer element idx (signed RES_W):
  - If OUT_WIDTH>=RES_W: m_data = sign-extended e, m_sat=0.
  - Else: e > 2^(OUT_WIDTH-1)-1 → max positive, m_sat=1; e < -2^(OUT_WIDTH-1) → min negative, m_sat=1; otherwise truncated e, m_sat=0.
- Mid-stream reset: rst during STREAM → IDLE next cycle, m_valid=0, buffer cleared, no further beats.
- The buffer is written only at capture; result_in changes after capture have no effect.

Test Plan:
- Basic order (WIDTH=8, ARRAY_SIZE=4, OUT_WIDTH=16):
  - Stimulus: result_in element i = i+1, start pulse, m_ready=1.
  - Required: 16 consecutive beats with m_data 1..16; (m_row,m_col) from (0,0) to (3,3); m_last only on beat 16; m_valid first high the cycle after start.
- Backpressure:
  - Stimulus: same data, m_ready toggling 1,0,0,1,…
  - Required: no beat lost or duplicated; m_data/m_row/m_col hold while m_ready=0; order unchanged.
- Saturation (RES_W=18):
  - Stimulus: element(0,0)=40000, (0,1)=-40000, (0,2)=32767, (0,3)=-5.
  - Required: m_data 32767/sat1, -32768/sat1, 32767/sat0, -5/sat0.
- Overrun and back-to-back:
  - Stimulus: start during beat 5 → overrun=1, stream continues with the original data.
  - Stimulus: start with data B on the beat-16 handshake → next cycle m_valid=1 with B element 0, busy never drops.
  - Stimulus: clr_overrun → overrun=0.
- Reset mid-stream:
  - Stimulus: assert rst at beat 7.
  - Required: next cycle m_valid=0, busy=0, overrun=0; a subsequent start restarts from element (0,0).
- Wide output:
  - Stimulus: OUT_WIDTH=20, element=-131072.
  - Required: m_data=-131072 sign-extended, m_sat=0.
